conv_phase_center_table: RTL

//  Consumer of the 32-bit load_centers software-register word (user_clk domain). Decodes load/clear commands into a
//  per-channel phase-center RAM. Subtracts the selected channel's center from the streaming phase data of the conv_phase stage.

---
 rtl/conv_phase_center_table.sv | 133 +++++++++++++
 1 files changed

// File: rtl/conv_phase_center_table.sv
// Per-channel phase-center table: register-word load/clear commands fill the RAM, and streaming phase is centred in 2 cycles.
// Optional build macro PHASE_CENTER_SAT_EN selects a saturating difference instead of the modulo (circular) wrap.
module conv_phase_center_table #(
  parameter int CH_W    = 8,
  parameter int PHASE_W = 16
) (
  input  logic                      user_clk,
  input  logic                      user_rst_n,
  input  logic [31:0]               load_centers_reg,
  input  logic                      phase_in_valid,
  input  logic signed [PHASE_W-1:0] phase_in,
  input  logic [CH_W-1:0]           phase_in_ch,
  output logic                      phase_out_valid,
  output logic signed [PHASE_W-1:0] phase_out,
  output logic [CH_W-1:0]           phase_out_ch,
  output logic                      busy,
  output logic                      load_err,
  output logic [15:0]               load_count
);
  localparam int DEPTH = 2**CH_W;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t              state, state_nxt;
  logic [CH_W-1:0]     addr, addr_nxt;
  logic                load_prev, clr_prev;
  logic                load_edge, clr_edge;
  logic                ram_we, err_set, cnt_inc;
  logic [CH_W-1:0]     ram_waddr;
  logic [PHASE_W-1:0]  ram_wdata;
  logic [PHASE_W-1:0]  ram [DEPTH];
  logic                unused_reg;

  logic                       vld_p1;
  logic signed [PHASE_W-1:0]  phase_p1, center_p1;
  logic [CH_W-1:0]            ch_p1;

  function automatic logic signed [PHASE_W-1:0] center_sub(
    input logic signed [PHASE_W-1:0] a,
    input logic signed [PHASE_W-1:0] b
  );
`ifdef PHASE_CENTER_SAT_EN
    logic [PHASE_W:0] d;
    d = {a[PHASE_W-1], a} - {b[PHASE_W-1], b};
    // Sign bit disagreeing with the top magnitude bit means the true difference left the PHASE_W range
    if (d[PHASE_W] != d[PHASE_W-1])
      return d[PHASE_W] ? {1'b1, {(PHASE_W-1){1'b0}}} : {1'b0, {(PHASE_W-1){1'b1}}};
    return d[PHASE_W-1:0];
`else
    return a - b;
`endif
  endfunction

  assign load_edge  = load_centers_reg[31] & ~load_prev;
  assign clr_edge   = load_centers_reg[30] & ~clr_prev;
  assign busy       = (state == CLEAR);
  assign unused_reg = ^load_centers_reg;

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    ram_we    = 1'b0;
    ram_waddr = load_centers_reg[16 +: CH_W];
    ram_wdata = load_centers_reg[PHASE_W-1:0];
    err_set   = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (clr_edge) begin
          state_nxt = CLEAR;
          addr_nxt  = '0;
          err_set   = load_edge;
        end else if (load_edge) begin
          ram_we  = 1'b1;
          cnt_inc = 1'b1;
        end
      end
      CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = addr;
        ram_wdata = '0;
        addr_nxt  = addr + CH_W'(1);
        err_set   = load_edge | clr_edge;
        if (addr == {CH_W{1'b1}}) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Edge registers reset high so a strobe held through reset is not a command
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state      <= IDLE;
      addr       <= '0;
      load_prev  <= 1'b1;
      clr_prev   <= 1'b1;
      load_err   <= 1'b0;
      load_count <= '0;
    end else begin
      state     <= state_nxt;
      addr      <= addr_nxt;
      load_prev <= load_centers_reg[31];
      clr_prev  <= load_centers_reg[30];
      if (err_set) load_err <= 1'b1;
      if (cnt_inc) load_count <= load_count + 16'd1;
    end
  end

  // Stage p1: table read (read-first against a same-cycle write) and sample capture
  always_ff @(posedge user_clk) begin
    if (ram_we) ram[ram_waddr] <= ram_wdata;
    center_p1 <= ram[phase_in_ch];
    phase_p1  <= phase_in;
    ch_p1     <= phase_in_ch;
  end

  // Stage p2: centred difference to the outputs, held while no sample is valid
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      vld_p1          <= 1'b0;
      phase_out_valid <= 1'b0;
      phase_out       <= '0;
      phase_out_ch    <= '0;
    end else begin
      vld_p1          <= phase_in_valid;
      phase_out_valid <= vld_p1;
      if (vld_p1) begin
        phase_out    <= center_sub(phase_p1, center_p1);
        phase_out_ch <= ch_p1;
      end
    end
  end
endmodule
